// File: rtl/cnn_pkg.sv
// Shared CNN pipeline constants: sample/map dimensions and max-pool FSM encodings.
package cnn_pkg;

   localparam int DATA_W = 16;
   localparam int MAX_W  = 256;
   localparam int SIZE_W = 9;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_EVEN_ROW = 2'd1;
   localparam logic [1:0] ST_ODD_ROW  = 2'd2;

   // A frame is accepted only when its edge length is poolable and fits the line buffer.
   function automatic logic size_ok(input logic [SIZE_W-1:0] s, input int max_w);
      return (s >= SIZE_W'(2)) && (s <= SIZE_W'(max_w));
   endfunction

endpackage

// File: rtl/max_pool_2x2_if.sv
// Stream bus between the normalisation stage and the 2x2 max-pool stage.
interface max_pool_2x2_if #(
   parameter int DATA_W = cnn_pkg::DATA_W
);
   logic [cnn_pkg::SIZE_W-1:0] map_size;
   logic signed [DATA_W-1:0]   pi_map;
   logic                       pi_map_valid;
   logic signed [DATA_W-1:0]   pool_out;
   logic                       pool_out_valid;
   logic                       pool_frame_done;

   modport master (
      output map_size, pi_map, pi_map_valid,
      input  pool_out, pool_out_valid, pool_frame_done
   );

   modport slave (
      input  map_size, pi_map, pi_map_valid,
      output pool_out, pool_out_valid, pool_frame_done
   );
endinterface

// File: rtl/max_pool_2x2_line_buf.sv
// Half-row buffer of horizontal pair maxima: synchronous write, combinational read.
module pool_line_buf #(
   parameter int DATA_W = cnn_pkg::DATA_W,
   parameter int DEPTH  = cnn_pkg::MAX_W / 2,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     sys_clk,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic signed [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic signed [DATA_W-1:0] rd_data
);

   logic signed [DATA_W-1:0] mem [DEPTH];

   // NOTE: storage has no reset; every entry is written on an even row before the odd row reads it.
   always_ff @(posedge sys_clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 max pool over raster-ordered square feature maps.
// Build option: define MAX_POOL_RELU_EN to clamp negative input samples to zero before pairing.
module max_pool_2x2
   import cnn_pkg::*;
#(
   parameter int DATA_W = cnn_pkg::DATA_W,
   parameter int MAX_W  = cnn_pkg::MAX_W
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   max_pool_2x2_if.slave pool_bus
);

   localparam int CNT_W  = $clog2(MAX_W);
   localparam int ADDR_W = CNT_W - 1;

   logic [1:0]               state;
   logic [SIZE_W-1:0]        size_q;
   logic [CNT_W-1:0]         col;
   logic [CNT_W-1:0]         row;
   logic signed [DATA_W-1:0] h_reg;
   logic signed [DATA_W-1:0] pool_out_q;
   logic                     pool_out_valid_q;
   logic                     pool_frame_done_q;

   logic signed [DATA_W-1:0] sample;
   logic signed [DATA_W-1:0] hmax;
   logic signed [DATA_W-1:0] vmax;
   logic signed [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0]        buf_addr;
   logic [SIZE_W-1:0]        last_idx;
   logic                     start;
   logic                     active;
   logic                     odd_col;
   logic                     row_end;
   logic                     frame_end;
   logic                     wr_en;

   function automatic logic signed [DATA_W-1:0] smax(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

`ifdef MAX_POOL_RELU_EN
   assign sample = pool_bus.pi_map[DATA_W-1] ? '0 : pool_bus.pi_map;
`else
   assign sample = pool_bus.pi_map;
`endif

   // IDLE holds col at 0, so the first sample of a frame always lands in h_reg.
   assign start     = pool_bus.pi_map_valid && (state == ST_IDLE)
                      && size_ok(pool_bus.map_size, MAX_W);
   assign active    = pool_bus.pi_map_valid && (state != ST_IDLE);
   assign odd_col   = col[0];
   assign buf_addr  = col[CNT_W-1:1];
   assign last_idx  = size_q - SIZE_W'(1);
   assign row_end   = (SIZE_W'(col) == last_idx);
   assign frame_end = row_end && (SIZE_W'(row) == last_idx);
   assign hmax      = smax(h_reg, sample);
   assign vmax      = smax(rd_data, hmax);
   assign wr_en     = active && odd_col && (state == ST_EVEN_ROW);

   pool_line_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (MAX_W / 2),
      .ADDR_W (ADDR_W)
   ) u_line_buf (
      .sys_clk (sys_clk),
      .wr_en   (wr_en),
      .wr_addr (buf_addr),
      .wr_data (hmax),
      .rd_addr (buf_addr),
      .rd_data (rd_data)
   );

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state             <= ST_IDLE;
         size_q            <= '0;
         col               <= '0;
         row               <= '0;
         h_reg             <= '0;
         pool_out_q        <= '0;
         pool_out_valid_q  <= 1'b0;
         pool_frame_done_q <= 1'b0;
      end else begin
         pool_out_valid_q  <= 1'b0;
         pool_frame_done_q <= 1'b0;

         if (start) begin
            size_q <= pool_bus.map_size;
            h_reg  <= sample;
            col    <= CNT_W'(1);
            row    <= '0;
            state  <= ST_EVEN_ROW;
         end else if (active) begin
            if (!odd_col) begin
               h_reg <= sample;
            end else if (state == ST_ODD_ROW) begin
               pool_out_q       <= vmax;
               pool_out_valid_q <= 1'b1;
            end

            if (row_end) begin
               col <= '0;
               if (frame_end) begin
                  row               <= '0;
                  state             <= ST_IDLE;
                  pool_frame_done_q <= 1'b1;
               end else begin
                  row   <= row + CNT_W'(1);
                  state <= (state == ST_EVEN_ROW) ? ST_ODD_ROW : ST_EVEN_ROW;
               end
            end else begin
               col <= col + CNT_W'(1);
            end
         end
      end
   end

   assign pool_bus.pool_out        = pool_out_q;
   assign pool_bus.pool_out_valid  = pool_out_valid_q;
   assign pool_bus.pool_frame_done = pool_frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2: frame-level reference model, cycle-exact expectations.
module tb_max_pool_2x2;
   import cnn_pkg::*;

   typedef struct {
      int value;
      int cyc;
   } exp_t;

   logic sys_clk = 1'b0;
   logic sys_rst_n;

   always #5 sys_clk = ~sys_clk;

   max_pool_2x2_if #(.DATA_W(DATA_W)) bus ();

   max_pool_2x2 #(
      .DATA_W (DATA_W),
      .MAX_W  (MAX_W)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .pool_bus  (bus)
   );

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   last_out = 0;
   int   done_count = 0;
   exp_t exp_q[$];
   int   done_q[$];
   int   got_q[$];

   // Reference model state: latched edge length, samples seen, whole frame so far.
   int   m_size = 0;
   int   m_n = 0;
   int   frame[$];

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int relu(input int v);
`ifdef MAX_POOL_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic model_accept(input int v, input int sz, input int at);
      int r, c, w;
      if (m_size == 0) begin
         if (sz < 2 || sz > MAX_W) return;
         m_size = sz;
         m_n    = 0;
         frame.delete();
      end
      frame.push_back(relu(v));
      r = m_n / m_size;
      c = m_n % m_size;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
         w = max2(max2(frame[(r-1)*m_size + c-1], frame[(r-1)*m_size + c]),
                  max2(frame[r*m_size + c-1],     frame[r*m_size + c]));
         exp_q.push_back('{value: w, cyc: at});
      end
      m_n++;
      if (m_n == m_size * m_size) begin
         done_q.push_back(at);
         m_size = 0;
      end
   endtask

   task automatic model_reset();
      m_size = 0;
      m_n    = 0;
      frame.delete();
      exp_q.delete();
      done_q.delete();
   endtask

   task automatic send(input int v, input int sz, input int gap);
      repeat (gap) begin
         @(negedge sys_clk);
         bus.pi_map_valid = 1'b0;
         bus.pi_map       = DATA_W'($urandom);
      end
      @(negedge sys_clk);
      bus.pi_map       = DATA_W'(v);
      bus.map_size     = SIZE_W'(sz);
      bus.pi_map_valid = 1'b1;
      model_accept(v, sz, cyc + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge sys_clk);
         bus.pi_map_valid = 1'b0;
         bus.pi_map       = DATA_W'($urandom);
      end
   endtask

   task automatic expect_got(input string name, input int e[$]);
      check({name, "_count"}, got_q.size(), e.size());
      for (int i = 0; i < e.size() && i < got_q.size(); i++)
         check($sformatf("%s_out%0d", name, i), got_q[i], e[i]);
      got_q.delete();
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      forever begin
         @(posedge sys_clk);
         cyc++;
         #1;
         if (!sys_rst_n) begin
            check("in_reset_pool_out", int'(bus.pool_out), 0);
            check("in_reset_valid", int'(bus.pool_out_valid), 0);
            check("in_reset_done", int'(bus.pool_frame_done), 0);
            last_out = 0;
         end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               check("output_missing_at_cycle", cyc, exp_q[0].cyc);
               void'(exp_q.pop_front());
            end
            while (done_q.size() > 0 && done_q[0] < cyc) begin
               check("done_missing_at_cycle", cyc, done_q[0]);
               void'(done_q.pop_front());
            end
            if (bus.pool_out_valid) begin
               if (exp_q.size() == 0) begin
                  check("spurious_output", int'(bus.pool_out_valid), 0);
               end else begin
                  check("output_cycle", cyc, exp_q[0].cyc);
                  check("output_value", int'(bus.pool_out), exp_q[0].value);
                  void'(exp_q.pop_front());
               end
               got_q.push_back(int'(bus.pool_out));
               last_out = int'(bus.pool_out);
            end else begin
               check("pool_out_hold", int'(bus.pool_out), last_out);
            end
            if (bus.pool_frame_done) begin
               done_count++;
               if (done_q.size() == 0) begin
                  check("spurious_done", int'(bus.pool_frame_done), 0);
               end else begin
                  check("done_cycle", cyc, done_q[0]);
                  void'(done_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int e[$];
      int d0;
      int sz, mid;

      bus.pi_map_valid = 1'b0;
      bus.pi_map       = '0;
      bus.map_size     = SIZE_W'(4);
      sys_rst_n        = 1'b0;
      repeat (3) @(negedge sys_clk);
      check("reset_pool_out", int'(bus.pool_out), 0);
      check("reset_valid", int'(bus.pool_out_valid), 0);
      check("reset_done", int'(bus.pool_frame_done), 0);
      sys_rst_n = 1'b1;
      idle(2);

      // 4x4 raster 0..15, continuous valid
      got_q.delete();
      for (int i = 0; i < 16; i++) send(i, 4, 0);
      idle(4);
      e = {5, 7, 13, 15};
      expect_got("t4x4", e);

      // Same frame with random valid gaps
      for (int i = 0; i < 16; i++) send(i, 4, $urandom_range(0, 3));
      idle(4);
      expect_got("t4x4_gaps", e);

      // 5x5 raster 0..24: last column/row never paired
      d0 = done_count;
      for (int i = 0; i < 25; i++) send(i, 5, 0);
      idle(4);
      e = {6, 8, 16, 18};
      expect_got("t5x5", e);
      check("t5x5_done_pulses", done_count - d0, 1);

      // Negative 2x2 window
      send(-5, 2, 0); send(-3, 2, 0); send(-9, 2, 0); send(-7, 2, 0);
      idle(3);
`ifdef MAX_POOL_RELU_EN
      e = {0};
`else
      e = {-3};
`endif
      expect_got("t2x2_neg", e);

      // Reset after 10 samples, then a fresh frame
      for (int i = 0; i < 10; i++) send(i, 4, 0);
      @(negedge sys_clk);
      bus.pi_map_valid = 1'b0;
      sys_rst_n        = 1'b0;
      model_reset();
      repeat (3) @(negedge sys_clk);
      check("mid_reset_pool_out", int'(bus.pool_out), 0);
      sys_rst_n = 1'b1;
      got_q.delete();
      for (int i = 0; i < 16; i++) send(i, 4, 0);
      idle(4);
      e = {5, 7, 13, 15};
      expect_got("t_after_reset", e);

      // Invalid size 1, then back-to-back 2x2 frames
      d0 = done_count;
      for (int i = 0; i < 3; i++) send(i + 20, 1, 0);
      send(1, 2, 0); send(2, 2, 0); send(3, 2, 0); send(4, 2, 0);
      send(8, 2, 0); send(7, 2, 0); send(6, 2, 0); send(5, 2, 0);
      idle(4);
      e = {4, 8};
      expect_got("t_b2b", e);
      check("t_b2b_done_pulses", done_count - d0, 2);

      // Randomized frames: random sizes, values, gaps, junk map_size mid-frame
      for (int f = 0; f < 24; f++) begin
         if ($urandom_range(0, 3) == 0) send($urandom_range(0, 100), $urandom_range(257, 511), 0);
         sz = (f == 23) ? 32 : $urandom_range(2, 11);
         for (int i = 0; i < sz * sz; i++) begin
            mid = (i == 0) ? sz : $urandom_range(0, 511);
            send(int'($urandom_range(0, 65535)) - 32768, mid,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
         end
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
      end
      idle(10);

      check("scoreboard_drained", exp_q.size(), 0);
      check("done_queue_drained", done_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/max_pool_2x2.md
# max_pool_2x2

Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of the convolution/normalisation stage. It consumes that stage's raster-ordered normalised feature-map samples (`map_out`/`map_out_valid`) and emits one pooled sample per 2×2 window. It also emits a one-cycle frame-done pulse after the last input sample of a frame. An optional ReLU clamp can be compiled in ahead of the comparators.

## Interface
Parameters:
- `DATA_W`, 16, sample width (signed two's complement).
- `MAX_W`, 256, largest supported feature-map width/height.

Ports:
- `sys_clk`  in  1  single clock; all logic is on its rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `map_size`  in  9  feature-map width = height; sampled only at the first sample of a frame.
- `pi_map`  in  16  signed input sample (upstream `map_out`).
- `pi_map_valid`  in  1  input qualifier (upstream `map_out_valid`); one sample per high cycle, gaps allowed.
- `pool_out`  out  16  signed pooled sample, registered.
- `pool_out_valid`  out  1  one-cycle pulse per pooled sample.
- `pool_frame_done`  out  1  one-cycle pulse after the last sample of a frame is accepted.

## Operation
- States:
  - IDLE: waiting for the first sample of a frame.
  - EVEN_ROW: processing rows 0, 2, 4, …
  - ODD_ROW: processing rows 1, 3, 5, …
- State changes, counter updates and buffer writes occur only on cycles where `pi_map_valid`=1. Idle cycles change nothing.
- IDLE, valid sample arrives:
  - If `map_size` is in 2..256: latch it as `size_q`, process the sample as row 0, column 0, and go to EVEN_ROW.
  - Otherwise: discard the sample and stay in IDLE. No output is produced.
- Column counter `col` runs 0..`size_q`-1. Row counter `row` runs 0..`size_q`-1. At the end of a row, `col` wraps to 0, `row` increments, and the state toggles EVEN_ROW↔ODD_ROW.
- Horizontal pairing:
  - Even `col`: store the sample in `h_reg`.
  - Odd `col`: `hmax` = signed max(`h_reg`, sample).
- EVEN_ROW, odd `col`: write `hmax` to `line_buf[col>>1]`.
- ODD_ROW, odd `col`: `pool_out` <= signed max(`line_buf[col>>1]`, `hmax`); pulse `pool_out_valid`.
- Odd `size_q`:
  - The last column of every row is consumed but never paired.
  - The last row is consumed as an EVEN_ROW, and its buffer writes are never read.
- Last sample of the frame (`row`=`col`=`size_q`-1): counters clear, state returns to IDLE, and `pool_frame_done` pulses on the next cycle.
- Comparisons are full-width signed. Equal operands may select either operand; the result is the same value.
- Output count per frame = floor(`size_q`/2)².

## Timing
- Reset values: `pool_out`=0, `pool_out_valid`=0, `pool_frame_done`=0, state=IDLE, counters=0, `h_reg`=0. `line_buf` is not reset, because every entry is written before it is read.
- Latency: `pool_out_valid` is high exactly 1 cycle after the accepted ODD_ROW odd-column sample. `pool_out` holds its value until the next pooled result.
- For even `size_q`, the final `pool_out_valid` and `pool_frame_done` assert in the same cycle.
- Back-to-back frames: a valid sample in the cycle immediately after the last sample is accepted as row 0, column 0 of the next frame, and `map_size` is re-latched. No bubble is required.
- `map_size` changes mid-frame are ignored until the next IDLE.
- Reset asserted mid-frame: all state is cleared immediately and any partial windows are discarded. The next valid sample after release starts a new frame.
- `line_buf` read is combinational (register array), so arbitrary valid gaps are tolerated.

## Configuration
- `MAX_POOL_RELU_EN`:
  - Defined: each input sample is clamped to 0 when negative, before pairing. `pool_out` is therefore ≥0.
  - Undefined: samples pass through unmodified, and negative maxima propagate.
- Latency and handshake are identical in both builds.

## Structure
- Shared package/header `cnn_pkg`: `DATA_W`, `MAX_W`, and the state encodings (IDLE=0, EVEN_ROW=1, ODD_ROW=2).
- One sub-module `pool_line_buf`:
  - `MAX_W/2` × `DATA_W` register array.
  - Synchronous write port (`wr_en`, `wr_addr`, `wr_data`).
  - Combinational read port (`rd_addr`, `rd_data`).
  - No reset.
- All control, counters and comparators live in the top module.

## Test plan
- 4×4 frame, values 0..15 raster, continuous valid -> `pool_out` 5, 7, 13, 15 on four pulses; `pool_frame_done` coincides with the last pulse.
- Same 4×4 frame with random 0–3 cycle valid gaps -> identical output sequence; no output on gap cycles.
- 5×5 frame, values 0..24 -> outputs 6, 8, 16, 18 only; `pool_frame_done` one cycle after sample 24.
- 2×2 frame {-5,-3,-9,-7} -> `pool_out`=-3 without `MAX_POOL_RELU_EN`; `pool_out`=0 with it.
- Reset asserted after 10 samples of a 4×4 frame, then a full fresh 4×4 frame (0..15) -> only 5, 7, 13, 15 appear; `pool_out`=0 while in reset.
- `map_size`=1 with 3 samples, then back-to-back 2×2 frames {1,2,3,4} and {8,7,6,5} -> no output for the size-1 samples, then 4 and 8, each with a `pool_frame_done` pulse.
